// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: EXE always owns port 0 when it writes, LOAD/MULT/DIV
// share the rest round-robin. Define WB_PERF_EN to build per-requester stall counters.
`ifdef WB_PERF_EN
module wb_stall_ctr (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_inc,
  output logic [15:0] o_cnt
);
  logic [15:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              r_cnt <= '0;
    else if (i_inc && r_cnt != 16'hFFFF)  r_cnt <= r_cnt + 16'd1;
  end

  assign o_cnt = r_cnt;
endmodule
`endif

module wb_port_arbiter #(
  parameter int XLEN      = 32,
  parameter int NREQ_LONG = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      exe_vld,
  input  logic [4:0]                exe_rd,
  input  logic [XLEN-1:0]           exe_data,
  input  logic [NREQ_LONG-1:0]      req_vld,
  input  logic [5*NREQ_LONG-1:0]    req_rd,
  input  logic [XLEN*NREQ_LONG-1:0] req_data,
  output logic [NREQ_LONG-1:0]      req_rdy,
  input  logic                      MEM_flush,
  output logic                      wr0_en,
  output logic [4:0]                wr0_rd,
  output logic [XLEN-1:0]           wr0_data,
  output logic                      wr1_en,
  output logic [4:0]                wr1_rd,
  output logic [XLEN-1:0]           wr1_data,
  output logic [1:0]                rel_vld,
  output logic [16*NREQ_LONG-1:0]   stall_cnt
);
  localparam int PW = (NREQ_LONG > 2) ? $clog2(NREQ_LONG) : 1;
  localparam int SW = PW + 1;
  typedef logic [PW-1:0] idx_t;

  logic [NREQ_LONG-1:0][4:0]      w_rd;
  logic [NREQ_LONG-1:0][XLEN-1:0] w_data;
  logic [NREQ_LONG-1:0]           w_elig, w_zero, w_cand, w_gnt;
  logic                           w_exe_port;
  logic                           w_g0_vld, w_g1_vld, w_g1_use;
  idx_t                           w_g0, w_g1, w_last, w_rr_nxt;
  logic                           w_p0_en, w_p1_en;
  logic [4:0]                     w_p0_rd, w_p1_rd;
  logic [XLEN-1:0]                w_p0_data, w_p1_data;

  idx_t                           r_rr_ptr;
  logic                           r_wr0_en, r_wr1_en;
  logic [4:0]                     r_wr0_rd, r_wr1_rd;
  logic [XLEN-1:0]                r_wr0_data, r_wr1_data;

  assign w_rd       = req_rd;
  assign w_data     = req_data;
  // An EXE write to x0 is architecturally void, so it leaves port 0 free.
  assign w_exe_port = exe_vld && (exe_rd != 5'd0);

  // A requester targeting the same rd as a live EXE write is deferred so the
  // younger EXE value is never overwritten by an older long-latency result.
  always_comb begin
    w_elig = '0;
    w_zero = '0;
    w_cand = '0;
    for (int i = 0; i < NREQ_LONG; i++) begin
      w_elig[i] = req_vld[i] && !(i == 0 && MEM_flush) &&
                  !(exe_vld && w_rd[i] != 5'd0 && w_rd[i] == exe_rd);
      w_zero[i] = w_elig[i] && (w_rd[i] == 5'd0);
      w_cand[i] = w_elig[i] && (w_rd[i] != 5'd0);
    end
  end

  // Round-robin scan from rr_ptr; the second pick must not share rd with the first.
  always_comb begin
    logic [SW-1:0] s;
    idx_t          idx;
    s        = '0;
    idx      = '0;
    w_g0_vld = 1'b0;
    w_g0     = '0;
    w_g1_vld = 1'b0;
    w_g1     = '0;
    for (int k = 0; k < NREQ_LONG; k++) begin
      s = {1'b0, r_rr_ptr} + SW'(k);
      if (s >= SW'(NREQ_LONG)) s = s - SW'(NREQ_LONG);
      idx = s[PW-1:0];
      if (w_cand[idx]) begin
        if (!w_g0_vld) begin
          w_g0_vld = 1'b1;
          w_g0     = idx;
        end else if (!w_g1_vld && w_rd[idx] != w_rd[w_g0]) begin
          w_g1_vld = 1'b1;
          w_g1     = idx;
        end
      end
    end
  end

  always_comb begin
    w_g1_use = w_g1_vld && !w_exe_port;
    w_gnt    = '0;
    if (w_g0_vld) w_gnt[w_g0] = 1'b1;
    if (w_g1_use) w_gnt[w_g1] = 1'b1;
    w_last   = w_g1_use ? w_g1 : w_g0;
    w_rr_nxt = (w_last == idx_t'(NREQ_LONG-1)) ? '0 : w_last + idx_t'(1);
  end

  always_comb begin
    w_p0_en   = 1'b0;
    w_p0_rd   = '0;
    w_p0_data = '0;
    w_p1_en   = 1'b0;
    w_p1_rd   = '0;
    w_p1_data = '0;
    if (w_exe_port) begin
      w_p0_en   = 1'b1;
      w_p0_rd   = exe_rd;
      w_p0_data = exe_data;
      if (w_g0_vld) begin
        w_p1_en   = 1'b1;
        w_p1_rd   = w_rd[w_g0];
        w_p1_data = w_data[w_g0];
      end
    end else begin
      if (w_g0_vld) begin
        w_p0_en   = 1'b1;
        w_p0_rd   = w_rd[w_g0];
        w_p0_data = w_data[w_g0];
      end
      if (w_g1_vld) begin
        w_p1_en   = 1'b1;
        w_p1_rd   = w_rd[w_g1];
        w_p1_data = w_data[w_g1];
      end
    end
  end

  assign req_rdy = rst ? '0 : (w_zero | w_gnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr   <= '0;
      r_wr0_en   <= 1'b0;
      r_wr0_rd   <= '0;
      r_wr0_data <= '0;
      r_wr1_en   <= 1'b0;
      r_wr1_rd   <= '0;
      r_wr1_data <= '0;
    end else begin
      if (w_g0_vld) r_rr_ptr <= w_rr_nxt;
      r_wr0_en   <= w_p0_en;
      r_wr0_rd   <= w_p0_rd;
      r_wr0_data <= w_p0_data;
      r_wr1_en   <= w_p1_en;
      r_wr1_rd   <= w_p1_rd;
      r_wr1_data <= w_p1_data;
    end
  end

  assign wr0_en   = r_wr0_en;
  assign wr0_rd   = r_wr0_rd;
  assign wr0_data = r_wr0_data;
  assign wr1_en   = r_wr1_en;
  assign wr1_rd   = r_wr1_rd;
  assign wr1_data = r_wr1_data;
  assign rel_vld  = {r_wr1_en, r_wr0_en};

`ifdef WB_PERF_EN
  for (genvar i = 0; i < NREQ_LONG; i++) begin : g_stall
    wb_stall_ctr u_ctr (
      .clk   (clk),
      .rst   (rst),
      .i_inc (req_vld[i] && !req_rdy[i]),
      .o_cnt (stall_cnt[16*i +: 16])
    );
  end
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus randomized traffic against
// a queue-based reference model of the port allocation rules.
module tb_wb_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        exe_vld;
  logic [4:0]  exe_rd;
  logic [31:0] exe_data;
  logic [2:0]  req_vld;
  logic [14:0] req_rd;
  logic [95:0] req_data;
  logic [2:0]  req_rdy;
  logic        MEM_flush;
  logic        wr0_en, wr1_en;
  logic [4:0]  wr0_rd, wr1_rd;
  logic [31:0] wr0_data, wr1_data;
  logic [1:0]  rel_vld;
  logic [47:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  // reference model state
  int          m_rr;
  int          m_stall[3];
  logic [2:0]  exp_rdy;
  int          nx_rr;
  logic        nx0_en, nx1_en, ex0_en, ex1_en;
  logic [4:0]  nx0_rd, nx1_rd, ex0_rd, ex1_rd;
  logic [31:0] nx0_d, nx1_d, ex0_d, ex1_d;

  always #5 clk = ~clk;

  wb_port_arbiter #(.XLEN(32), .NREQ_LONG(3)) dut (
    .clk(clk), .rst(rst), .exe_vld(exe_vld), .exe_rd(exe_rd), .exe_data(exe_data),
    .req_vld(req_vld), .req_rd(req_rd), .req_data(req_data), .req_rdy(req_rdy),
    .MEM_flush(MEM_flush),
    .wr0_en(wr0_en), .wr0_rd(wr0_rd), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_rd(wr1_rd), .wr1_data(wr1_data),
    .rel_vld(rel_vld), .stall_cnt(stall_cnt)
  );

  function automatic void model_reset();
    m_rr = 0;
    for (int i = 0; i < 3; i++) m_stall[i] = 0;
    ex0_en = 0; ex0_rd = 0; ex0_d = 0;
    ex1_en = 0; ex1_rd = 0; ex1_d = 0;
  endfunction

  // Winners are listed in round-robin order, each taking the next free port.
  function automatic void model_eval();
    int         gq[$];
    int         slots, i;
    logic [4:0] r;
    bit         ok, clash;
    exp_rdy = '0;
    nx0_en = 0; nx0_rd = 0; nx0_d = 0;
    nx1_en = 0; nx1_rd = 0; nx1_d = 0;
    nx_rr = m_rr;
    slots = 2;
    if (exe_vld && exe_rd != 5'd0) begin
      slots = 1; nx0_en = 1; nx0_rd = exe_rd; nx0_d = exe_data;
    end
    for (int k = 0; k < 3; k++) begin
      i  = (m_rr + k) % 3;
      r  = req_rd[5*i +: 5];
      ok = req_vld[i] && !(i == 0 && MEM_flush) && !(exe_vld && r != 5'd0 && r == exe_rd);
      if (!ok) continue;
      if (r == 5'd0) begin exp_rdy[i] = 1'b1; continue; end
      clash = 0;
      foreach (gq[j]) if (req_rd[5*gq[j] +: 5] == r) clash = 1;
      if (!clash && gq.size() < slots) begin
        gq.push_back(i);
        exp_rdy[i] = 1'b1;
      end
    end
    foreach (gq[j]) begin
      if (!nx0_en) begin
        nx0_en = 1; nx0_rd = req_rd[5*gq[j] +: 5]; nx0_d = req_data[32*gq[j] +: 32];
      end else begin
        nx1_en = 1; nx1_rd = req_rd[5*gq[j] +: 5]; nx1_d = req_data[32*gq[j] +: 32];
      end
    end
    if (gq.size() > 0) nx_rr = (gq[gq.size()-1] + 1) % 3;
    if (rst) exp_rdy = '0;
  endfunction

  task automatic tick();
    model_eval();
    for (int i = 0; i < 3; i++)
      if (!rst && req_vld[i] && !exp_rdy[i] && m_stall[i] < 65535) m_stall[i]++;
    @(posedge clk);
    if (rst) model_reset();
    else begin
      m_rr = nx_rr;
      ex0_en = nx0_en; ex0_rd = nx0_rd; ex0_d = nx0_d;
      ex1_en = nx1_en; ex1_rd = nx1_rd; ex1_d = nx1_d;
    end
    #1;
  endtask

  task automatic idle_inputs();
    exe_vld = 0; exe_rd = 0; exe_data = 0;
    req_vld = 0; req_rd = 0; req_data = 0; MEM_flush = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    exe_vld = 0; exe_rd = 0; exe_data = 0; MEM_flush = 0;
    req_vld = 3'b111; req_rd = {5'd3, 5'd2, 5'd1};
    req_data = {32'h33, 32'h22, 32'h11};
    @(posedge clk); #2;
    total++; if (req_rdy !== 3'b000) begin bad++; $display("FAIL reset_rdy got=%b exp=000", req_rdy); end
    total++; if (wr0_en !== 1'b0 || wr1_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b%b exp=00", wr1_en, wr0_en); end
    total++; if (rel_vld !== 2'b00 || wr0_rd !== 5'd0 || wr0_data !== 32'd0) begin bad++; $display("FAIL reset_regs rel=%b rd=%0d data=%h exp 0", rel_vld, wr0_rd, wr0_data); end
    rst = 1'b0;
    model_reset();
    #1;
    total++; if (req_rdy !== 3'b011) begin bad++; $display("FAIL reset_first_rdy got=%b exp=011", req_rdy); end
    tick();
    total++; if (wr0_en !== 1'b1 || wr0_rd !== 5'd1 || wr0_data !== 32'h11) begin bad++; $display("FAIL reset_first_load got=%b/%0d/%h exp=1/1/11", wr0_en, wr0_rd, wr0_data); end
    total++; if (wr1_en !== 1'b1 || wr1_rd !== 5'd2 || wr1_data !== 32'h22) begin bad++; $display("FAIL reset_first_mult got=%b/%0d/%h exp=1/2/22", wr1_en, wr1_rd, wr1_data); end
  endtask

  task automatic test_exe_priority();
    do_reset();
    req_vld = 3'b001; req_rd = {5'd0, 5'd0, 5'd1}; req_data = {32'h0, 32'h0, 32'h44};
    #2;
    total++; if (req_rdy !== 3'b001) begin bad++; $display("FAIL exe_pre_rdy got=%b exp=001", req_rdy); end
    tick();
    exe_vld = 1; exe_rd = 5'd5; exe_data = 32'h11;
    req_vld = 3'b110; req_rd = {5'd7, 5'd6, 5'd0}; req_data = {32'h33, 32'h22, 32'h0};
    #2;
    total++; if (req_rdy !== 3'b010) begin bad++; $display("FAIL exe_rdy got=%b exp=010", req_rdy); end
    tick();
    total++; if (wr0_rd !== 5'd5 || wr0_data !== 32'h11 || wr1_rd !== 5'd6 || wr1_data !== 32'h22 || rel_vld !== 2'b11)
      begin bad++; $display("FAIL exe_ports got=%0d/%h %0d/%h rel=%b exp=5/11 6/22 rel=11", wr0_rd, wr0_data, wr1_rd, wr1_data, rel_vld); end
    exe_vld = 0; req_vld = 3'b100;
    #2;
    total++; if (req_rdy !== 3'b100) begin bad++; $display("FAIL exe_div_rdy got=%b exp=100", req_rdy); end
    tick();
    total++; if (wr0_en !== 1'b1 || wr0_rd !== 5'd7 || wr0_data !== 32'h33 || wr1_en !== 1'b0)
      begin bad++; $display("FAIL exe_div_port got=%b/%0d/%h wr1_en=%b exp=1/7/33 0", wr0_en, wr0_rd, wr0_data, wr1_en); end
    req_vld = 3'b111; req_rd = {5'd3, 5'd2, 5'd1};
    #2;
    total++; if (req_rdy !== 3'b011) begin bad++; $display("FAIL exe_rr_wrap got=%b exp=011", req_rdy); end
    tick();
  endtask

  task automatic test_waw();
    do_reset();
    exe_vld = 1; exe_rd = 5'd9; exe_data = 32'hAA;
    req_vld = 3'b001; req_rd = {5'd0, 5'd0, 5'd9}; req_data = {32'h0, 32'h0, 32'hBB};
    #2;
    total++; if (req_rdy !== 3'b000) begin bad++; $display("FAIL waw_defer got=%b exp=000", req_rdy); end
    tick();
    total++; if (wr0_en !== 1'b1 || wr0_rd !== 5'd9 || wr0_data !== 32'hAA || wr1_en !== 1'b0)
      begin bad++; $display("FAIL waw_exe got=%b/%0d/%h wr1_en=%b exp=1/9/aa 0", wr0_en, wr0_rd, wr0_data, wr1_en); end
    exe_rd = 5'd10; exe_data = 32'hCC;
    #2;
    total++; if (req_rdy !== 3'b001) begin bad++; $display("FAIL waw_release got=%b exp=001", req_rdy); end
    tick();
    total++; if (wr0_rd !== 5'd10 || wr0_data !== 32'hCC || wr1_en !== 1'b1 || wr1_rd !== 5'd9 || wr1_data !== 32'hBB)
      begin bad++; $display("FAIL waw_ports got=%0d/%h %b/%0d/%h exp=10/cc 1/9/bb", wr0_rd, wr0_data, wr1_en, wr1_rd, wr1_data); end
    idle_inputs();
    tick();
    total++; if (rel_vld !== 2'b00) begin bad++; $display("FAIL waw_pulse got=%b exp=00", rel_vld); end
  endtask

  task automatic test_flush();
    do_reset();
    MEM_flush = 1;
    req_vld = 3'b011; req_rd = {5'd0, 5'd4, 5'd3}; req_data = {32'h0, 32'h44, 32'h33};
    #2;
    total++; if (req_rdy !== 3'b010) begin bad++; $display("FAIL flush_rdy got=%b exp=010", req_rdy); end
    tick();
    total++; if (wr0_en !== 1'b1 || wr0_rd !== 5'd4 || wr0_data !== 32'h44 || wr1_en !== 1'b0)
      begin bad++; $display("FAIL flush_ports got=%b/%0d/%h wr1_en=%b exp=1/4/44 0", wr0_en, wr0_rd, wr0_data, wr1_en); end
  endtask

  task automatic test_rd0();
    do_reset();
    req_vld = 3'b110; req_rd = 15'd0; req_data = '0;
    #2;
    total++; if (req_rdy !== 3'b110) begin bad++; $display("FAIL rd0_rdy got=%b exp=110", req_rdy); end
    tick();
    total++; if (wr0_en !== 1'b0 || wr1_en !== 1'b0) begin bad++; $display("FAIL rd0_ports got=%b%b exp=00", wr1_en, wr0_en); end
    exe_vld = 1; exe_rd = 5'd0; exe_data = 32'h55;
    req_vld = 3'b011; req_rd = {5'd0, 5'd2, 5'd1}; req_data = {32'h0, 32'h22, 32'h11};
    #2;
    total++; if (req_rdy !== 3'b011) begin bad++; $display("FAIL rd0_exe_rdy got=%b exp=011", req_rdy); end
    tick();
    total++; if (wr0_rd !== 5'd1 || wr0_data !== 32'h11 || wr1_rd !== 5'd2 || rel_vld !== 2'b11)
      begin bad++; $display("FAIL rd0_exe_ports got=%0d/%h %0d rel=%b exp=1/11 2 rel=11", wr0_rd, wr0_data, wr1_rd, rel_vld); end
  endtask

  task automatic test_collision();
    do_reset();
    req_vld = 3'b110; req_rd = {5'd8, 5'd8, 5'd0}; req_data = {32'h90, 32'h80, 32'h0};
    #2;
    total++; if (req_rdy !== 3'b010) begin bad++; $display("FAIL coll_rdy got=%b exp=010", req_rdy); end
    tick();
    total++; if (wr0_rd !== 5'd8 || wr0_data !== 32'h80 || wr1_en !== 1'b0)
      begin bad++; $display("FAIL coll_first got=%0d/%h wr1_en=%b exp=8/80 0", wr0_rd, wr0_data, wr1_en); end
    req_vld = 3'b100;
    #2;
    total++; if (req_rdy !== 3'b100) begin bad++; $display("FAIL coll_second_rdy got=%b exp=100", req_rdy); end
    tick();
    total++; if (wr0_rd !== 5'd8 || wr0_data !== 32'h90) begin bad++; $display("FAIL coll_second got=%0d/%h exp=8/90", wr0_rd, wr0_data); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_vld = 3'b010; req_rd = {5'd0, 5'd4, 5'd0}; req_data = {32'h0, 32'h44, 32'h0};
    tick();
    rst = 1'b1;
    #1;
    total++; if (wr0_en !== 1'b0 || rel_vld !== 2'b00) begin bad++; $display("FAIL midrst_clear got=%b rel=%b exp=0 00", wr0_en, rel_vld); end
    rst = 1'b0;
    model_reset();
    req_vld = 3'b111; req_rd = {5'd3, 5'd2, 5'd1};
    #1;
    total++; if (req_rdy !== 3'b011) begin bad++; $display("FAIL midrst_rr got=%b exp=011", req_rdy); end
    tick();
  endtask

  task automatic test_back_to_back();
    int g[3];
    int ungranted;
    do_reset();
    g = '{0, 0, 0};
    ungranted = 0;
    exe_vld = 1; exe_rd = 5'd10;
    req_vld = 3'b111; req_rd = {5'd3, 5'd2, 5'd1};
    for (int c = 0; c < 10; c++) begin
      exe_data = $urandom;
      req_data = {$urandom, $urandom, $urandom};
      #2;
      model_eval();
      total++; if (req_rdy !== exp_rdy) begin bad++; $display("FAIL b2b_rdy cyc=%0d got=%b exp=%b", c, req_rdy, exp_rdy); end
      for (int i = 0; i < 3; i++) begin
        if (req_rdy[i]) g[i]++;
        if (!exp_rdy[i]) ungranted++;
      end
      tick();
      total++; if (wr0_data !== ex0_d || wr1_en !== ex1_en || wr1_rd !== ex1_rd || wr1_data !== ex1_d)
        begin bad++; $display("FAIL b2b_ports cyc=%0d got=%h %b/%0d/%h exp=%h %b/%0d/%h", c, wr0_data, wr1_en, wr1_rd, wr1_data, ex0_d, ex1_en, ex1_rd, ex1_d); end
    end
    for (int i = 0; i < 3; i++) begin
      total++; if (g[i] < 3) begin bad++; $display("FAIL b2b_starve req=%0d got=%0d grants exp>=3", i, g[i]); end
    end
`ifdef WB_PERF_EN
    total++;
    if (32'(stall_cnt[15:0]) + 32'(stall_cnt[31:16]) + 32'(stall_cnt[47:32]) != 32'(ungranted) || ungranted != 20)
      begin bad++; $display("FAIL b2b_stall_sum got=%0d/%0d/%0d exp sum=%0d", stall_cnt[15:0], stall_cnt[31:16], stall_cnt[47:32], ungranted); end
`endif
  endtask

  task automatic test_random();
    logic [4:0]  prd[3];
    logic [31:0] pdat[3];
    bit          pv[3];
    for (int i = 0; i < 3; i++) begin pv[i] = 0; prd[i] = 0; pdat[i] = 0; end
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!pv[i] && $urandom_range(0, 1) == 1) begin
          pv[i] = 1; prd[i] = 5'($urandom_range(0, 7)); pdat[i] = $urandom;
        end
        req_vld[i] = pv[i];
        req_rd[5*i +: 5] = prd[i];
        req_data[32*i +: 32] = pdat[i];
      end
      exe_vld = 1'($urandom_range(0, 1));
      exe_rd = 5'($urandom_range(0, 7));
      exe_data = $urandom;
      MEM_flush = ($urandom_range(0, 4) == 0);
      #2;
      model_eval();
      total++; if (req_rdy !== exp_rdy) begin bad++; $display("FAIL rnd_rdy cyc=%0d got=%b exp=%b", n, req_rdy, exp_rdy); end
      for (int i = 0; i < 3; i++) if (exp_rdy[i]) pv[i] = 0;
      tick();
      total++; if (wr0_en !== ex0_en || (ex0_en && (wr0_rd !== ex0_rd || wr0_data !== ex0_d)))
        begin bad++; $display("FAIL rnd_wr0 cyc=%0d got=%b/%0d/%h exp=%b/%0d/%h", n, wr0_en, wr0_rd, wr0_data, ex0_en, ex0_rd, ex0_d); end
      total++; if (wr1_en !== ex1_en || (ex1_en && (wr1_rd !== ex1_rd || wr1_data !== ex1_d)))
        begin bad++; $display("FAIL rnd_wr1 cyc=%0d got=%b/%0d/%h exp=%b/%0d/%h", n, wr1_en, wr1_rd, wr1_data, ex1_en, ex1_rd, ex1_d); end
      total++; if (rel_vld !== {ex1_en, ex0_en}) begin bad++; $display("FAIL rnd_rel cyc=%0d got=%b exp=%b", n, rel_vld, {ex1_en, ex0_en}); end
    end
`ifdef WB_PERF_EN
    for (int i = 0; i < 3; i++) begin
      total++; if (stall_cnt[16*i +: 16] !== 16'(m_stall[i]))
        begin bad++; $display("FAIL rnd_stall req=%0d got=%0d exp=%0d", i, stall_cnt[16*i +: 16], m_stall[i]); end
    end
`else
    total++; if (stall_cnt !== 48'd0) begin bad++; $display("FAIL perf_off got=%h exp=0", stall_cnt); end
`endif
  endtask

`ifdef WB_PERF_EN
  task automatic test_perf_sat();
    do_reset();
    MEM_flush = 1;
    req_vld = 3'b001; req_rd = {5'd0, 5'd0, 5'd3};
    repeat (70000) @(posedge clk);
    #1;
    total++; if (stall_cnt[15:0] !== 16'hFFFF) begin bad++; $display("FAIL perf_sat got=%h exp=ffff", stall_cnt[15:0]); end
    total++; if (stall_cnt[47:16] !== 32'd0) begin bad++; $display("FAIL perf_sat_others got=%h exp=0", stall_cnt[47:16]); end
    do_reset();
    total++; if (stall_cnt !== 48'd0) begin bad++; $display("FAIL perf_reset got=%h exp=0", stall_cnt); end
  endtask
`endif

  initial begin
    idle_inputs();
    model_reset();
    rst = 1'b1;
    #2;
    test_reset();
    test_exe_priority();
    test_waw();
    test_flush();
    test_rd0();
    test_collision();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef WB_PERF_EN
    test_perf_sat();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
